// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: mid-bit sampling, parity/stop checks,
// one-entry valid/ready holding register with frame/overrun flags.
`timescale 1ns/1ps
module uart_rx_oversampled #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rxIn,
   output logic [DATA_BITS-1:0] rxData,
   output logic                 rxValid,
   input  logic                 rxReady,
   output logic                 parityErr,
   output logic                 frameErr,
   output logic                 overrunErr,
   output logic                 busy
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS);

   localparam logic [BW-1:0] HALF  = BW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] FULL  = BW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LASTD = IW'(DATA_BITS - 1);
   localparam logic [IW-1:0] LASTS = IW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_sync1;
   logic                  r_sync2;
   logic [BW-1:0]         r_bitCnt;
   logic [IW-1:0]         r_idxCnt;
   logic [DATA_BITS-1:0]  r_shift;
   logic                  r_parErrInt;
   logic [DATA_BITS-1:0]  r_data;
   logic                  r_valid;
   logic                  r_parErr;
   logic                  r_frameErr;
   logic                  r_overrun;

   logic w_rxS;
   logic w_bitEnd;
   logic w_cntClr;
   logic w_idxClr;
   logic w_idxInc;
   logic w_shiftEn;
   logic w_parEn;
   logic w_parClr;
   logic w_ferr;
   logic w_done;
   logic w_parX;
   logic w_parBad;

   assign w_rxS    = r_sync2;
   assign w_bitEnd = (r_bitCnt == FULL);
   assign w_parX   = (^r_shift) ^ w_rxS;
   assign w_parBad = (PARITY == 1) ? ~w_parX : w_parX;

   // Two-flop synchroniser for the asynchronous serial line, idle high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rxIn;
         r_sync2 <= r_sync1;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and per-cycle datapath strobes
   always_comb begin
      w_state_nxt = r_state;
      w_cntClr    = 1'b0;
      w_idxClr    = 1'b0;
      w_idxInc    = 1'b0;
      w_shiftEn   = 1'b0;
      w_parEn     = 1'b0;
      w_parClr    = 1'b0;
      w_ferr      = 1'b0;
      w_done      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (!w_rxS) begin
               w_state_nxt = S_START;
               w_cntClr    = 1'b1;
               w_idxClr    = 1'b1;
               w_parClr    = 1'b1;
            end
         end
         S_START: begin
            if (r_bitCnt == HALF) begin
               w_cntClr    = 1'b1;
               w_state_nxt = w_rxS ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (w_bitEnd) begin
               w_cntClr  = 1'b1;
               w_shiftEn = 1'b1;
               if (r_idxCnt == LASTD) begin
                  w_idxClr    = 1'b1;
                  w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  w_idxInc = 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (w_bitEnd) begin
               w_cntClr    = 1'b1;
               w_parEn     = 1'b1;
               w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (w_bitEnd) begin
               w_cntClr = 1'b1;
               if (!w_rxS) begin
                  w_ferr      = 1'b1;
                  w_state_nxt = S_BREAK;
               end else if (r_idxCnt == LASTS) begin
                  w_done      = 1'b1;
                  w_idxClr    = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_idxInc = 1'b1;
               end
            end
         end
         S_BREAK: begin
            if (w_rxS) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Oversampling bit timer and data/stop bit index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bitCnt <= '0;
         r_idxCnt <= '0;
      end else begin
         if (w_cntClr || r_state == S_IDLE || r_state == S_BREAK) begin
            r_bitCnt <= '0;
         end else begin
            r_bitCnt <= r_bitCnt + 1'b1;
         end
         if (w_idxClr) begin
            r_idxCnt <= '0;
         end else if (w_idxInc) begin
            r_idxCnt <= r_idxCnt + 1'b1;
         end
      end
   end

   // Shift register (LSB first, new bit at MSB) and parity check
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift     <= '0;
         r_parErrInt <= 1'b0;
      end else begin
         if (w_shiftEn) begin
            r_shift <= {w_rxS, r_shift[DATA_BITS-1:1]};
         end
         if (w_parClr) begin
            r_parErrInt <= 1'b0;
         end else if (w_parEn) begin
            r_parErrInt <= w_parBad;
         end
      end
   end

   // Holding register, handshake and error pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_parErr   <= 1'b0;
         r_frameErr <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_frameErr <= w_ferr;
         r_overrun  <= 1'b0;
         if (w_done) begin
            if (!r_valid || rxReady) begin
               r_data   <= r_shift;
               r_parErr <= r_parErrInt;
               r_valid  <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && rxReady) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign rxData     = r_data;
   assign rxValid    = r_valid;
   assign parityErr  = r_parErr & r_valid;
   assign frameErr   = r_frameErr;
   assign overrunErr = r_overrun;
   assign busy       = (r_state != S_IDLE);

endmodule
